// File: rtl/link_router_pkg.sv
// Shared definitions for the input link router lanes and their per-lane subunit buffers.
package link_router_pkg;

  localparam int LINK_WORD_W   = 40;
  localparam int NUM_LANES     = 4;
  localparam int BUF_DEPTH     = 8;
  localparam int BUF_AF_MARGIN = 2;

  typedef struct packed {
    logic [LINK_WORD_W-1:0] header;
    logic [LINK_WORD_W-1:0] payload;
  } lane_entry_t;

endpackage

// File: rtl/fifo_ram_2p.sv
// DEPTH x DATA_W register array: one synchronous write port, one combinational read port.
module fifo_ram_2p #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 80
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset; occupancy tracking makes stale words invisible.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/subunit_input_buffer.sv
// Per-lane first-word-fall-through receive FIFO between router egress and one hardware subunit.
// Optional drop counter output enabled by SUBUNIT_INPUT_BUFFER_DROP_COUNT_EN.
module subunit_input_buffer
  import link_router_pkg::*;
#(
  parameter int DEPTH     = BUF_DEPTH,
  parameter int WORD_W    = LINK_WORD_W,
  parameter int AF_MARGIN = BUF_AF_MARGIN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  input  logic [WORD_W-1:0]      header_in,
  input  logic [WORD_W-1:0]      payload_in,
  output logic                   buffer_ready,
  output logic                   full,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [WORD_W-1:0]      header_out,
  output logic [WORD_W-1:0]      payload_out,
  output logic [$clog2(DEPTH):0] count,
  output logic                   drop
`ifdef SUBUNIT_INPUT_BUFFER_DROP_COUNT_EN
  ,
  output logic [15:0]            drop_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(DEPTH - AF_MARGIN);

  logic [PTR_W-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic                drop_reg, drop_next;
  logic                rd_fire, wr_fire;
  logic [2*WORD_W-1:0] wr_data, rd_data;

  assign rd_valid     = (count_reg != '0);
  assign full         = (count_reg == CNT_FULL);
  assign buffer_ready = (count_reg < CNT_AF);
  assign count        = count_reg;
  assign drop         = drop_reg;

  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign rd_fire = rd_valid && rd_ready;
  assign wr_fire = wr_valid && (!full || rd_fire);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    drop_next   = wr_valid && !wr_fire;
    if (wr_fire) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (rd_fire) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end
    unique case ({wr_fire, rd_fire})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      drop_reg   <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      drop_reg   <= drop_next;
    end
  end

  assign wr_data = {header_in, payload_in};

  fifo_ram_2p #(
    .DEPTH (DEPTH),
    .DATA_W(2 * WORD_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_fire),
    .waddr(wr_ptr_reg),
    .wdata(wr_data),
    .raddr(rd_ptr_reg),
    .rdata(rd_data)
  );

  // Outputs are forced to zero while empty so stale memory never leaks to the subunit.
  assign header_out  = rd_valid ? rd_data[2*WORD_W-1 -: WORD_W] : '0;
  assign payload_out = rd_valid ? rd_data[WORD_W-1:0]           : '0;

`ifdef SUBUNIT_INPUT_BUFFER_DROP_COUNT_EN
  logic [15:0] drop_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count_reg <= '0;
    end else if (drop_next && (drop_count_reg != 16'hFFFF)) begin
      drop_count_reg <= drop_count_reg + 16'd1;
    end
  end

  assign drop_count = drop_count_reg;
`else
  // Counter absent; discarded writes are signalled only by the drop pulse.
`endif

endmodule

// File: tb/tb_subunit_input_buffer.sv
// Scoreboard bench for subunit_input_buffer: directed stimulus pushes expected entries, a monitor pops on reads.
module tb_subunit_input_buffer;
  import link_router_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_valid = 1'b0;
  logic        rd_ready = 1'b0;
  logic [39:0] header_in = '0;
  logic [39:0] payload_in = '0;
  logic        buffer_ready, full, rd_valid, drop;
  logic [39:0] header_out, payload_out;
  logic [3:0]  count;
`ifdef SUBUNIT_INPUT_BUFFER_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  lane_entry_t sb[$];
  lane_entry_t mon_e;

  always #5 clk = ~clk;

  subunit_input_buffer #(
    .DEPTH    (8),
    .WORD_W   (40),
    .AF_MARGIN(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .header_in   (header_in),
    .payload_in  (payload_in),
    .buffer_ready(buffer_ready),
    .full        (full),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .header_out  (header_out),
    .payload_out (payload_out),
    .count       (count),
    .drop        (drop)
`ifdef SUBUNIT_INPUT_BUFFER_DROP_COUNT_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic lane_entry_t ent(input int i);
    lane_entry_t e;
    e.header  = {8'hA0, 32'(i)};
    e.payload = {8'h5C, 32'(i * 3 + 1)};
    return e;
  endfunction

  // Called at posedge+1; applies inputs for one cycle and returns at the next posedge+1.
  task automatic drive(input logic wv, input logic [39:0] h, input logic [39:0] p, input logic rr);
    wr_valid   = wv;
    header_in  = h;
    payload_in = p;
    rd_ready   = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_push(input int i, input logic rr);
    lane_entry_t e;
    e = ent(i);
    sb.push_back(e);
    drive(1'b1, e.header, e.payload, rr);
    $display("write entry %0d hdr=%h pay=%h count=%0d", i, e.header, e.payload, count);
  endtask

  task automatic drain();
    int k = 0;
    while (rd_valid && k < 40) begin
      drive(1'b0, '0, '0, 1'b1);
      k++;
    end
    chk("drain_done", rd_valid, 0);
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_count", count, 0);
    rd_ready = 1'b0;
  endtask

  task automatic do_reset();
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    rst      = 1'b1;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted read is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: got hdr=%h expected no entry", header_out);
      end else begin
        mon_e = sb.pop_front();
        $display("read hdr=%h pay=%h", header_out, payload_out);
        chk("rd_header", header_out, mon_e.header);
        chk("rd_payload", payload_out, mon_e.payload);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset then idle
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, '0, '0, 1'b0);
      chk("idle_count", count, 0);
      chk("idle_full", full, 0);
      chk("idle_buffer_ready", buffer_ready, 1);
      chk("idle_rd_valid", rd_valid, 0);
      chk("idle_drop", drop, 0);
      chk("idle_header_out", header_out, 0);
    end

    // Single entry
    sb.push_back('{header: 40'h01_0000_00AA, payload: 40'h00_1234_5678});
    drive(1'b1, 40'h01_0000_00AA, 40'h00_1234_5678, 1'b0);
    chk("single_rd_valid", rd_valid, 1);
    chk("single_header", header_out, 40'h01_0000_00AA);
    chk("single_payload", payload_out, 40'h00_1234_5678);
    chk("single_count", count, 1);
    drive(1'b0, '0, '0, 1'b1);
    chk("single_count_after_read", count, 0);
    chk("single_header_zero", header_out, 0);
    chk("single_payload_zero", payload_out, 0);

    // Fill and flags
    for (int i = 0; i < 8; i++) begin
      wr_push(10 + i, 1'b0);
      chk("fill_count", count, i + 1);
      chk("fill_full", full, (i == 7));
      chk("fill_buffer_ready", buffer_ready, (i < 5));
    end
    drive(1'b1, 40'hDE_AD00_0000, 40'hBE_EF00_0000, 1'b0);
    chk("overflow_drop", drop, 1);
    chk("overflow_count", count, 8);
    chk("overflow_head", header_out, {8'hA0, 32'd10});
    drive(1'b0, '0, '0, 1'b0);
    chk("overflow_drop_clear", drop, 0);
    chk("overflow_count_hold", count, 8);

    // Full with simultaneous read and write; entry 18 must come out last
    wr_push(18, 1'b1);
    chk("fullrw_count", count, 8);
    chk("fullrw_drop", drop, 0);
    chk("fullrw_head", header_out, {8'hA0, 32'd11});
    drain();

    // Empty with simultaneous write and rd_ready
    wr_push(30, 1'b1);
    chk("emptyrw_count", count, 1);
    chk("emptyrw_rd_valid", rd_valid, 1);
    drain();

    // Wrap-around stream
    for (int i = 0; i < 5; i++) wr_push(100 + i, 1'b0);
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) wr_push(200 + k / 2, 1'b0);
      else drive(1'b0, '0, '0, 1'b1);
      chk("wrap_count_le8", (count <= 8), 1);
    end
    chk("wrap_count_end", count, 5);
    drain();

    // Overflows then reset mid-stream
    do_reset();
`ifdef SUBUNIT_INPUT_BUFFER_DROP_COUNT_EN
    chk("dropcnt_after_reset", drop_count, 0);
`endif
    for (int i = 0; i < 8; i++) wr_push(40 + i, 1'b0);
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 40'h11_1111_1111, 40'h22_2222_2222, 1'b0);
      chk("ovf3_drop", drop, 1);
      chk("ovf3_count", count, 8);
    end
`ifdef SUBUNIT_INPUT_BUFFER_DROP_COUNT_EN
    chk("dropcnt_three", drop_count, 3);
`endif
    for (int j = 0; j < 3; j++) drive(1'b0, '0, '0, 1'b1);
    chk("midrst_count_before", count, 5);
    rd_ready = 1'b0;
    wr_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_full", full, 0);
    chk("midrst_buffer_ready", buffer_ready, 1);
    chk("midrst_header", header_out, 0);
    chk("midrst_drop", drop, 0);
`ifdef SUBUNIT_INPUT_BUFFER_DROP_COUNT_EN
    chk("midrst_drop_count", drop_count, 0);
`endif
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("postrst_count", count, 0);
    wr_push(60, 1'b0);
    chk("postrst_write_count", count, 1);
    chk("postrst_header", header_out, {8'hA0, 32'd60});
    drain();

    drive(1'b0, '0, '0, 1'b0);
    chk("final_sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/subunit_input_buffer.md
Name: subunit_input_buffer

Overview:
Per-lane receive FIFO that sits directly downstream of the input link router egress stage. It holds one 40-bit header and one 40-bit payload per entry, and presents them first-word-fall-through to one hardware subunit. Its full flag drives one bit of the router's hardware_subunit_input_buffer_full bus. Its buffer_ready output drives the matching buffer_readyN input of the egress stage. Four instances cover lanes 0-3.

Parameters:
DEPTH, 8, number of header/payload entries; power of two, minimum 4.
WORD_W, 40, width of each header word and each payload word.
AF_MARGIN, 2, free entries still remaining when buffer_ready deasserts; covers egress reaction latency.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
wr_valid  input  1  egress presents an entry this cycle.
header_in  input  WORD_W  header word from header_arrayN.
payload_in  input  WORD_W  payload word from payload_arrayN.
buffer_ready  output  1  space available; to egress buffer_readyN.
full  output  1  count == DEPTH; to hardware_subunit_input_buffer_full[N].
rd_valid  output  1  head entry valid.
rd_ready  input  1  subunit consumes head entry this cycle.
header_out  output  WORD_W  head header word.
payload_out  output  WORD_W  head payload word.
count  output  $clog2(DEPTH)+1  current occupancy.
drop  output  1  one-cycle pulse; a write was discarded.

Behaviour:
- Reset (async assert, sync release): write pointer, read pointer and count = 0. full=0, rd_valid=0, drop=0, buffer_ready=1. header_out and payload_out = 0. Memory contents are not reset.
- Write accepted when wr_valid && (!full || rd_fire), where rd_fire = rd_valid && rd_ready. The entry is stored at wr_ptr and wr_ptr increments modulo DEPTH. The pointer is $clog2(DEPTH) bits wide and wraps naturally.
- Read fires on rd_fire. rd_ptr increments modulo DEPTH.
- rd_ready while rd_valid=0 has no effect.
- Count update: +1 on write only, -1 on read only, unchanged on both or neither. Count never exceeds DEPTH and never goes below 0.
- FWFT: rd_valid = (count != 0). header_out and payload_out show mem[rd_ptr] whenever rd_valid=1, and show 0 when rd_valid=0.
- Latency: an entry written at edge k is visible with rd_valid=1 after edge k. Minimum write-to-read latency is 1 cycle; there is no combinational bypass.
- full = (count == DEPTH), combinational from registered count.
- buffer_ready = (count < DEPTH - AF_MARGIN), combinational from registered count.
- Full plus simultaneous read and write: both are accepted, count stays at DEPTH, and no drop occurs.
- Empty plus simultaneous write and rd_ready: the write is accepted and the read is ignored. Count goes to 1.
- Overflow: wr_valid while full and no rd_fire means the entry is discarded. State is unchanged and drop pulses high for the following cycle.
- Reset mid-operation: all queued entries are lost immediately. Outputs return to their reset values asynchronously.

Optional Feature:
Macro: SUBUNIT_INPUT_BUFFER_DROP_COUNT_EN.
- Enabled: adds output drop_count [15:0]. It increments once per discarded write, saturates at 16'hFFFF, and resets to 0 on rst.
- Disabled: the port and its counter are absent, and the drop pulse is unchanged.

Decomposition:
- Shared package link_router_pkg:
  - LINK_WORD_W = 40
  - NUM_LANES = 4
  - default buffer DEPTH = 8 and AF_MARGIN = 2
  - typedef lane_entry_t = struct {header[39:0], payload[39:0]}
- One natural sub-module: fifo_ram_2p. It is a DEPTH x 80-bit register array with one synchronous write port and one combinational read port.
- Pointer, count and flag logic stay in subunit_input_buffer.

Test Plan:
- Reset then idle: after rst, expect count=0, full=0, buffer_ready=1, rd_valid=0, drop=0 with no activity for 10 cycles.
- Single entry: write header=40'h01_0000_00AA, payload=40'h00_1234_5678 with rd_ready=0. Next cycle expect rd_valid=1 with both values on the outputs. Then pulse rd_ready; expect count=0.
- Fill and flags (DEPTH=8, rd_ready=0): write 8 entries. Expect buffer_ready=0 from count=6, and full=1 at count=8. A 9th write pulses drop for one cycle and leaves count=8. Drain in order 0..7.
- Full with simultaneous read and write: at count=8, assert wr_valid and rd_ready together. Expect count=8, drop=0, and the new entry emerging last.
- Wrap-around: stream 20 entries with rd_ready toggling every other cycle. Expect exact order, no loss, and count never above 8.
- Reset mid-stream: assert rst with count=5. Expect count=0, rd_valid=0, full=0 immediately. With SUBUNIT_INPUT_BUFFER_DROP_COUNT_EN, first run 3 overflows, expect drop_count=3, then confirm drop_count=0 after reset.
